// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: initiator side of the bit-cell RAM interface.
// Takes one read or write request at a time over a valid/ready handshake.
// It drives the one-hot select, r_w and in strobes to the cell bank, and it
// returns exactly one response for every request it accepts.
// Optional feature macro: RAM_CTRL_WRITE_VERIFY_EN. When it is defined, every
// write gets an extra VERIFY cycle that reads the word back and compares it.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1. req_ready is 1 only while the controller is idle.
// Requests made while busy are ignored, and nothing is queued. rsp_valid is
// a single-cycle pulse with no back-pressure. rsp_rdata and rsp_err keep
// their value until the next response.
module ram_access_ctrl #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2,
    localparam int DEPTH = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [DEPTH-1:0]  mem_sel,
    output logic              mem_r_w,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out,
    output logic              mem_clear,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_VERIFY = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  cap_q;
    logic [DEPTH-1:0]   sel_onehot;

    assign req_ready  = (state_q == ST_IDLE);
    assign accept     = req_valid & req_ready;
    assign mem_clear  = clear;
    assign state_dbg  = state_q;
    assign sel_onehot = {{(DEPTH-1){1'b0}}, 1'b1} << addr_q;

    // Register the state and latch the request fields on acceptance.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Compute the next state. The sequence is IDLE -> ACCESS -> [VERIFY] -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid) state_d = ST_ACCESS;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
            ST_ACCESS: state_d = we_q ? ST_VERIFY : ST_RESP;
`else
            ST_ACCESS: state_d = ST_RESP;
`endif
            ST_VERIFY: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Capture the cell data on the edge that ends the access or verify cycle,
    // then present it together with the one-cycle response pulse.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cap_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= (state_q == ST_RESP);
            if (state_q == ST_ACCESS)
                cap_q <= we_q ? '0 : mem_out;
            else if (state_q == ST_VERIFY)
                cap_q <= mem_out;
            if (state_q == ST_RESP)
                rsp_rdata <= cap_q;
        end
    end

`ifdef RAM_CTRL_WRITE_VERIFY_EN
    logic err_q;
    logic rsp_err_q;

    assign rsp_err = rsp_err_q;

    // Compare the readback with the written data and hold the result until the next response.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            err_q     <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            if (state_q == ST_ACCESS)
                err_q <= 1'b0;
            else if (state_q == ST_VERIFY)
                err_q <= (mem_out != wdata_q);
            if (state_q == ST_RESP)
                rsp_err_q <= err_q;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

    // Update the memory strobes on the falling edge only, so they stay steady
    // while clk is high and the gated cell clock cannot glitch.
    always_ff @(negedge clk or posedge clear) begin
        if (clear) begin
            mem_sel <= '0;
            mem_r_w <= 1'b0;
            mem_in  <= '0;
        end else begin
            case (state_q)
                ST_ACCESS: begin
                    mem_sel <= sel_onehot;
                    mem_r_w <= we_q;
                    mem_in  <= we_q ? wdata_q : '0;
                end
                ST_VERIFY: begin
                    mem_sel <= sel_onehot;
                    mem_r_w <= 1'b0;
                    mem_in  <= '0;
                end
                default: begin
                    mem_sel <= '0;
                    mem_r_w <= 1'b0;
                    mem_in  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed bench for ram_access_ctrl with a behavioural cell bank.
// Build with RAM_CTRL_WRITE_VERIFY_EN defined to also cover verified writes.
module tb_ram_access_ctrl;

    localparam int DW = 4;
    localparam int AW = 2;
    localparam int DP = 4;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
    localparam int WLAT = 3;
    localparam bit VFY  = 1'b1;
`else
    localparam int WLAT = 2;
    localparam bit VFY  = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clear;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [DP-1:0] mem_sel;
    logic          mem_r_w;
    logic [DW-1:0] mem_in;
    logic [DW-1:0] mem_out;
    logic          mem_clear;
    logic [1:0]    state_dbg;

    int total = 0;
    int bad   = 0;

    // clock / reset block
    always #5 clk = ~clk;

    ram_access_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .clear     (clear),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_sel   (mem_sel),
        .mem_r_w   (mem_r_w),
        .mem_in    (mem_in),
        .mem_out   (mem_out),
        .mem_clear (mem_clear),
        .state_dbg (state_dbg)
    );

    // Behavioural cell bank. Each word is written through sel & r_w & clk,
    // each output is gated by its select, and the outputs are ORed together.
    logic [DW-1:0] cells [DP];
    logic          force_b0 = 1'b0;

    always @(posedge clk or posedge mem_clear) begin
        if (mem_clear) begin
            for (int i = 0; i < DP; i++) cells[i] <= '0;
        end else begin
            for (int i = 0; i < DP; i++)
                if (mem_sel[i] && mem_r_w) cells[i] <= mem_in;
        end
    end

    always_comb begin
        mem_out = '0;
        for (int i = 0; i < DP; i++)
            if (mem_sel[i]) mem_out = mem_out | cells[i];
        if (force_b0) mem_out[0] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: one request, checking the strobes, the response latency and the data
    task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input logic [DP-1:0] exp_sel);
        int got;
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        #1 chk("ready_idle", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("ready_busy", req_ready, 0);
        @(negedge clk);
        #1 chk("access_sel", mem_sel, exp_sel);
        chk("access_rw", mem_r_w, we);
        chk("access_in", mem_in, we ? wdata : '0);
        got = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) chk("sel_hold_posedge", mem_sel, exp_sel);
            if (rsp_valid) begin
                got = i;
                break;
            end
        end
        chk("rsp_latency", got, exp_lat);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", rsp_err, exp_err);
        @(posedge clk);
        #1 chk("rsp_pulse_end", rsp_valid, 0);
        chk("rsp_rdata_hold", rsp_rdata, exp_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int pulses;
        logic [DP-1:0] sel_b;
        logic          rw_b;

        clear = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;

        // 1: reset
        repeat (2) @(posedge clk);
        #1 chk("mem_clear_hi", mem_clear, 1);
        chk("sel_in_clear", mem_sel, 0);
        @(negedge clk);
        clear = 1'b0;
        #1 chk("mem_clear_lo", mem_clear, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_sel", mem_sel, 0);
        chk("rst_rw", mem_r_w, 0);
        chk("rst_in", mem_in, 0);
        chk("rst_state", state_dbg, 0);

        // 2: write then read address 1
        do_req(1'b1, 2'd1, 4'b0011, VFY ? 4'b0011 : 4'b0000, 1'b0, WLAT, 4'b0010);
        do_req(1'b0, 2'd1, 4'b0000, 4'b0011, 1'b0, 2, 4'b0010);

        // 3: no aliasing between words
        do_req(1'b1, 2'd2, 4'b0010, VFY ? 4'b0010 : 4'b0000, 1'b0, WLAT, 4'b0100);
        do_req(1'b0, 2'd0, 4'b1111, 4'b0000, 1'b0, 2, 4'b0001);
        do_req(1'b0, 2'd2, 4'b0000, 4'b0010, 1'b0, 2, 4'b0100);

        // 4: req_valid held for 6 cycles gives two accepts; strobes never move on posedge
        @(negedge clk);
        req_we = 1'b0; req_addr = 2'd2; req_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (req_ready) acc++;
            sel_b = mem_sel;
            rw_b  = mem_r_w;
            @(posedge clk);
            #1 chk("sel_stable_posedge", mem_sel, sel_b);
            chk("rw_stable_posedge", mem_r_w, rw_b);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("accepts_in_6", acc, 2);
        repeat (4) @(posedge clk);

        // 5: clear during the ACCESS of a write aborts it
        @(negedge clk);
        req_we = 1'b1; req_addr = 2'd1; req_wdata = 4'b1111; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        #1 chk("abort_sel_before", mem_sel, 4'b0010);
        chk("abort_rw_before", mem_r_w, 1);
        #2 clear = 1'b1;
        #1 chk("abort_sel", mem_sel, 0);
        chk("abort_rw", mem_r_w, 0);
        chk("abort_in", mem_in, 0);
        chk("abort_ready", req_ready, 1);
        pulses = 0;
        @(posedge clk);
        #1 pulses += int'(rsp_valid);
        @(negedge clk);
        clear = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1 pulses += int'(rsp_valid);
        end
        chk("abort_no_rsp", pulses, 0);
        do_req(1'b0, 2'd1, 4'b0000, 4'b0000, 1'b0, 2, 4'b0010);

`ifdef RAM_CTRL_WRITE_VERIFY_EN
        // 6: verified writes, clean and with a stuck-at-0 readback bit
        do_req(1'b1, 2'd3, 4'b0101, 4'b0101, 1'b0, 3, 4'b1000);
        force_b0 = 1'b1;
        do_req(1'b1, 2'd3, 4'b0101, 4'b0100, 1'b1, 3, 4'b1000);
        force_b0 = 1'b0;
`endif

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
